sram_port_arbiter: RTL and testbench

Two-master to one-slave arbiter that merges the core's instruction and data SRAM-like ports onto a single SRAM-like bus, so the core can run against one unified memory interface, such as a later AXI bridge. It sits between `mycpu_core` (IF/EX/MEM fetch and load/store traffic) and the downstream memory. It allows one outstanding transaction at a time, with fixed or round-robin priority. The requester-side handshakes (`addr_ok`/`data_ok`) feed the core's stall requests.

---
 rtl/sram_port_arbiter.sv | 121 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Merges the instruction and data SRAM-like ports onto one SRAM-like master bus, one outstanding transaction.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed data-over-inst priority.
module sram_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              m_req,
  output logic              m_wr,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0]        state;
  logic              owner_data;
  logic              wr_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              grant_data;
  logic              addr_ok_any;
  logic              data_ok_any;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic last_grant_data;

  // On a conflict, the port that did not win last time gets the grant.
  assign grant_data = data_req && (!inst_req || !last_grant_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_data <= 1'b0;
    end else if (state == ST_IDLE && (inst_req || data_req)) begin
      last_grant_data <= grant_data;
    end
  end
`else
  assign grant_data = data_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner_data <= 1'b0;
      wr_q       <= 1'b0;
      size_q     <= 2'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (inst_req || data_req) begin
            state      <= ST_ADDR;
            owner_data <= grant_data;
            wr_q       <= grant_data ? data_wr    : inst_wr;
            size_q     <= grant_data ? data_size  : inst_size;
            addr_q     <= grant_data ? data_addr  : inst_addr;
            wdata_q    <= grant_data ? data_wdata : inst_wdata;
          end
        end
        ST_ADDR: begin
          if (m_addr_ok) begin
            state <= m_data_ok ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (m_data_ok) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign m_req   = (state == ST_ADDR);
  assign m_wr    = wr_q;
  assign m_size  = size_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign busy    = (state != ST_IDLE);

  // Slave handshakes pass straight through to the owner; reset suppresses them.
  assign addr_ok_any = !rst && (state == ST_ADDR) && m_addr_ok;
  assign data_ok_any = !rst && (((state == ST_ADDR) && m_addr_ok && m_data_ok) ||
                                ((state == ST_DATA) && m_data_ok));

  assign inst_addr_ok = addr_ok_any && !owner_data;
  assign inst_data_ok = data_ok_any && !owner_data;
  assign data_addr_ok = addr_ok_any && owner_data;
  assign data_data_ok = data_ok_any && owner_data;
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_sram_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]        inst_size;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_wdata, inst_rdata;
  logic              data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata, data_rdata;
  logic              m_req, m_wr, m_addr_ok, m_data_ok, busy;
  logic [1:0]        m_size;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = '0; inst_wdata = '0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = '0; data_wdata = '0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    logic [3:0] oks;
    do_reset();
    @(negedge clk);
    oks = {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok};
    n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL reset_m_req got %0h want 0", m_req); end
    n_checks++; if (m_wr !== 1'b0) begin n_fail++; $display("FAIL reset_m_wr got %0h want 0", m_wr); end
    n_checks++; if (m_size !== 2'd0) begin n_fail++; $display("FAIL reset_m_size got %0h want 0", m_size); end
    n_checks++; if (m_addr !== '0) begin n_fail++; $display("FAIL reset_m_addr got %0h want 0", m_addr); end
    n_checks++; if (m_wdata !== '0) begin n_fail++; $display("FAIL reset_m_wdata got %0h want 0", m_wdata); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0h want 0", busy); end
    n_checks++; if (oks !== 4'b0000) begin n_fail++; $display("FAIL reset_oks got %b want 0000", oks); end
  endtask

  task automatic test_single_fetch();
    logic [3:0] oks;
    do_reset();
    inst_req = 1; inst_wr = 0; inst_size = 2; inst_addr = 32'hBFC00000;
    @(negedge clk);
    n_checks++; if ({m_req, busy} !== 2'b00) begin n_fail++; $display("FAIL fetch_c0 got req/busy %b want 00", {m_req, busy}); end
    tick();
    m_addr_ok = 1;
    @(negedge clk);
    oks = {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok};
    n_checks++; if ({m_req, busy, oks} !== 6'b111000) begin n_fail++; $display("FAIL fetch_c1 got %b want 111000", {m_req, busy, oks}); end
    n_checks++; if ({m_wr, m_size, m_addr} !== {1'b0, 2'd2, 32'hBFC00000}) begin n_fail++; $display("FAIL fetch_fields got %0h/%0h/%0h want 0/2/bfc00000", m_wr, m_size, m_addr); end
    tick();
    inst_req = 0; m_addr_ok = 0;
    @(negedge clk);
    oks = {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok};
    n_checks++; if ({m_req, busy, oks} !== 6'b010000) begin n_fail++; $display("FAIL fetch_c2 got %b want 010000", {m_req, busy, oks}); end
    tick();
    m_data_ok = 1; m_rdata = 32'h3C04BFAF;
    @(negedge clk);
    oks = {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok};
    n_checks++; if ({m_req, oks} !== 5'b00100) begin n_fail++; $display("FAIL fetch_c3 got %b want 00100", {m_req, oks}); end
    n_checks++; if (inst_rdata !== 32'h3C04BFAF) begin n_fail++; $display("FAIL fetch_rdata got %0h want 3c04bfaf", inst_rdata); end
    tick();
    m_data_ok = 0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fetch_c4_busy got %0h want 0", busy); end
  endtask

  task automatic test_conflict_fixed();
    logic [3:0] oks;
    do_reset();
    inst_req = 1; inst_wr = 0; inst_size = 2; inst_addr = 32'hBFC00004;
    data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h80001000; data_wdata = 32'h12345678;
    tick();
    m_addr_ok = 1;
    @(negedge clk);
    oks = {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok};
    n_checks++; if ({m_req, m_wr, m_addr, m_wdata} !== {1'b1, 1'b1, 32'h80001000, 32'h12345678}) begin n_fail++; $display("FAIL conflict_first got req%0h wr%0h %0h %0h want 1 1 80001000 12345678", m_req, m_wr, m_addr, m_wdata); end
    n_checks++; if (oks !== 4'b0010) begin n_fail++; $display("FAIL conflict_first_oks got %b want 0010", oks); end
    tick();
    data_req = 0; m_addr_ok = 0; m_data_ok = 1;
    @(negedge clk);
    oks = {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok};
    n_checks++; if (oks !== 4'b0001) begin n_fail++; $display("FAIL conflict_data_done got %b want 0001", oks); end
    tick();
    m_data_ok = 0;
    @(negedge clk);
    n_checks++; if ({m_req, busy} !== 2'b00) begin n_fail++; $display("FAIL conflict_gap got %b want 00", {m_req, busy}); end
    tick();
    m_addr_ok = 1;
    @(negedge clk);
    oks = {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok};
    n_checks++; if ({m_req, m_wr, m_addr} !== {1'b1, 1'b0, 32'hBFC00004}) begin n_fail++; $display("FAIL conflict_second got req%0h wr%0h %0h want 1 0 bfc00004", m_req, m_wr, m_addr); end
    n_checks++; if (oks !== 4'b1000) begin n_fail++; $display("FAIL conflict_second_oks got %b want 1000", oks); end
    tick();
    inst_req = 0; m_addr_ok = 0; m_data_ok = 1;
    @(negedge clk);
    n_checks++; if (inst_data_ok !== 1'b1) begin n_fail++; $display("FAIL conflict_inst_done got %0h want 1", inst_data_ok); end
    tick();
    m_data_ok = 0;
  endtask

  // Both ports keep requesting; the sequence of grants follows the priority rule.
  task automatic test_priority_stream();
    logic exp_order [3];
    logic got_order [3];
    int   ngrant;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    exp_order = '{1'b1, 1'b0, 1'b1};
`else
    exp_order = '{1'b1, 1'b1, 1'b1};
`endif
    got_order = '{1'b0, 1'b0, 1'b0};
    ngrant = 0;
    do_reset();
    inst_req = 1; inst_addr = 32'hBFC00010; data_req = 1; data_addr = 32'h80002000;
    m_addr_ok = 1; m_data_ok = 1;
    for (int c = 0; c < 40 && ngrant < 3; c++) begin
      @(negedge clk);
      if (inst_addr_ok || data_addr_ok) begin
        got_order[ngrant] = data_addr_ok;
        ngrant++;
      end
      tick();
    end
    idle_inputs();
    n_checks++; if (ngrant != 3) begin n_fail++; $display("FAIL prio_grants got %0d want 3", ngrant); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got_order[i] !== exp_order[i]) begin n_fail++; $display("FAIL prio_order[%0d] got data=%0d want data=%0d", i, got_order[i], exp_order[i]); end
    end
    tick();
    tick();
  endtask

  task automatic test_combined();
    logic [3:0] oks;
    do_reset();
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h80000010;
    tick();
    m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'hCAFEF00D;
    @(negedge clk);
    oks = {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok};
    n_checks++; if ({m_req, m_addr, oks} !== {1'b1, 32'h80000010, 4'b0011}) begin n_fail++; $display("FAIL combined_oks got req%0h %0h %b want 1 80000010 0011", m_req, m_addr, oks); end
    n_checks++; if (data_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL combined_rdata got %0h want cafef00d", data_rdata); end
    tick();
    data_req = 0; m_addr_ok = 0; m_data_ok = 0;
    @(negedge clk);
    n_checks++; if ({m_req, busy} !== 2'b00) begin n_fail++; $display("FAIL combined_after got %b want 00", {m_req, busy}); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] oks;
    do_reset();
    inst_req = 1; inst_addr = 32'hBFC00020; inst_size = 2;
    tick();
    m_addr_ok = 1;
    tick();
    inst_req = 0; m_addr_ok = 0;
    @(negedge clk);
    n_checks++; if ({m_req, busy} !== 2'b01) begin n_fail++; $display("FAIL rstmid_in_data got %b want 01", {m_req, busy}); end
    tick();
    rst = 1;
    @(negedge clk);
    oks = {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok};
    n_checks++; if (oks !== 4'b0000) begin n_fail++; $display("FAIL rstmid_rst_cycle got %b want 0000", oks); end
    tick();
    rst = 0; m_data_ok = 1;
    @(negedge clk);
    oks = {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok};
    n_checks++; if ({m_req, busy, oks} !== 6'b000000) begin n_fail++; $display("FAIL rstmid_after got %b want 000000", {m_req, busy, oks}); end
    tick();
    m_data_ok = 0;
  endtask

  task automatic test_spurious();
    logic [3:0] oks;
    do_reset();
    m_data_ok = 1; m_rdata = 32'hDEADBEEF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      oks = {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok};
      n_checks++; if ({m_req, busy, oks} !== 6'b000000) begin n_fail++; $display("FAIL spurious[%0d] got %b want 000000", c, {m_req, busy, oks}); end
      tick();
    end
    m_data_ok = 0;
  endtask

  // Randomized requesters and slave; expectations come from a transaction-level model.
  task automatic test_random();
    bit              act, in_data_phase, own_data, last_data;
    logic            l_wr;
    logic [1:0]      l_size;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    bit              ip, dp;
    logic [5:0]      exp_ctl, got_ctl;
    bit              e_aok, e_dok;
    act = 0; in_data_phase = 0; own_data = 0; last_data = 0; ip = 0; dp = 0;
    l_wr = 0; l_size = 0; l_addr = '0; l_wdata = '0;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (!ip && $urandom_range(0, 2) == 0) begin
        ip = 1; inst_wr = 1'($urandom_range(0, 1)); inst_size = 2'($urandom_range(0, 2));
        inst_addr = $urandom; inst_wdata = $urandom;
      end
      if (!dp && $urandom_range(0, 2) == 0) begin
        dp = 1; data_wr = 1'($urandom_range(0, 1)); data_size = 2'($urandom_range(0, 2));
        data_addr = $urandom; data_wdata = $urandom;
      end
      inst_req = ip; data_req = dp;
      m_addr_ok = 1'($urandom_range(0, 1));
      m_data_ok = 1'($urandom_range(0, 1));
      m_rdata = $urandom;
      @(negedge clk);
      e_aok = act && !in_data_phase && m_addr_ok;
      e_dok = act && ((!in_data_phase && m_addr_ok && m_data_ok) || (in_data_phase && m_data_ok));
      exp_ctl = {act && !in_data_phase, act, e_aok && !own_data, e_dok && !own_data, e_aok && own_data, e_dok && own_data};
      got_ctl = {m_req, busy, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok};
      n_checks++;
      if (got_ctl !== exp_ctl) begin n_fail++; $display("FAIL rand_ctl cyc%0d got %b want %b", c, got_ctl, exp_ctl); end
      if (act && !in_data_phase) begin
        n_checks++;
        if ({m_wr, m_size, m_addr, m_wdata} !== {l_wr, l_size, l_addr, l_wdata})
          begin n_fail++; $display("FAIL rand_fields cyc%0d got %0h/%0h/%0h/%0h want %0h/%0h/%0h/%0h", c, m_wr, m_size, m_addr, m_wdata, l_wr, l_size, l_addr, l_wdata); end
      end
      if (e_dok) begin
        n_checks++;
        if ((own_data ? data_rdata : inst_rdata) !== m_rdata) begin n_fail++; $display("FAIL rand_rdata cyc%0d got %0h want %0h", c, own_data ? data_rdata : inst_rdata, m_rdata); end
      end
      if (act) begin
        if (!in_data_phase && m_addr_ok) begin
          if (own_data) dp = 0; else ip = 0;
          if (m_data_ok) act = 0; else in_data_phase = 1;
        end else if (in_data_phase && m_data_ok) begin
          act = 0;
        end
      end else if (ip || dp) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        own_data = dp && (!ip || !last_data);
`else
        own_data = dp;
`endif
        last_data = own_data;
        act = 1; in_data_phase = 0;
        l_wr = own_data ? data_wr : inst_wr;
        l_size = own_data ? data_size : inst_size;
        l_addr = own_data ? data_addr : inst_addr;
        l_wdata = own_data ? data_wdata : inst_wdata;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_conflict_fixed();
    test_priority_stream();
    test_combined();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
